hamming74_serial_decoder: RTL and testbench

//   Receive side of the (7,4) Hamming link. Deserialises 7-bit codewords
//   (parity layout matching bin_2_hamming_pair), corrects any single-bit

---
 rtl/hamming74_serial_decoder.sv | 113 +++++++++++
 tb/tb_hamming74_serial_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_serial_decoder.sv
// Receive side of the (7,4) Hamming link: deserialises codewords LSB first,
// corrects single-bit errors and hands the BCD digit out on a valid/ready port.
module hamming74_serial_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             corrected,
  output logic [2:0]       err_pos,
  output logic             range_err,
  output logic [CNT_W-1:0] corr_count
);

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [6:0] shreg;
  logic [2:0] bitcnt;
  logic       accept;

  logic [2:0] syndrome;
  logic [7:0] onehot;
  logic [6:0] fixed;
  logic [3:0] fixed_data;

  assign accept = in_valid && in_ready;

  // Syndrome points at the 1-based bad position; bit 0 of the one-hot is the
  // "no error" slot, so dropping it yields the flip mask without a branch.
  always_comb begin
    syndrome[0] = shreg[0] ^ shreg[2] ^ shreg[4] ^ shreg[6];
    syndrome[1] = shreg[1] ^ shreg[2] ^ shreg[5] ^ shreg[6];
    syndrome[2] = shreg[3] ^ shreg[4] ^ shreg[5] ^ shreg[6];
    onehot      = 8'd1 << syndrome;
    fixed       = shreg ^ onehot[7:1];
    fixed_data  = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECV;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && bitcnt == 3'd6) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_next = RECV;
        end
      end
      default: begin
        state_next = RECV;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bitcnt     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      corrected  <= 1'b0;
      err_pos    <= '0;
      range_err  <= 1'b0;
      corr_count <= '0;
    end else begin
      if (accept) begin
        shreg[bitcnt] <= in_bit;
        bitcnt        <= (bitcnt == 3'd6) ? 3'd0 : bitcnt + 3'd1;
      end
      if (state == DECODE) begin
        out_data  <= fixed_data;
        corrected <= (syndrome != 3'd0);
        err_pos   <= syndrome;
        range_err <= (fixed_data > 4'd9);
        out_valid <= 1'b1;
        if (syndrome != 3'd0 && corr_count != {CNT_W{1'b1}}) begin
          corr_count <= corr_count + 1'b1;
        end
      end
      if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hamming74_serial_decoder.sv
// Self-checking bench for hamming74_serial_decoder: table of codewords with
// hand-derived results plus directed backpressure, reset and saturation runs.
module tb_hamming74_serial_decoder;

  logic       clk;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       corrected;
  logic [2:0] err_pos;
  logic       range_err;
  logic [7:0] corr_count;

  logic       sat_in_ready;
  logic [3:0] sat_out_data;
  logic       sat_out_valid;
  logic       sat_corrected;
  logic [2:0] sat_err_pos;
  logic       sat_range_err;
  logic [1:0] sat_corr_count;

  int checks;
  int failures;
  int model_cnt;

  typedef struct {
    logic [6:0] code;
    logic [3:0] exp_data;
    logic       exp_corr;
    logic [2:0] exp_pos;
    logic       exp_range;
  } vec_t;

  vec_t vecs[$];

  hamming74_serial_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .corrected(corrected), .err_pos(err_pos),
    .range_err(range_err), .corr_count(corr_count)
  );

  hamming74_serial_decoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(sat_in_ready), .out_data(sat_out_data), .out_valid(sat_out_valid),
    .out_ready(out_ready), .corrected(sat_corrected), .err_pos(sat_err_pos),
    .range_err(sat_range_err), .corr_count(sat_corr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoder written from the parity equations, independent of the decoder.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] h;
    h[2] = d[0];
    h[4] = d[1];
    h[5] = d[2];
    h[6] = d[3];
    h[0] = d[0] ^ d[1] ^ d[3];
    h[1] = d[0] ^ d[2] ^ d[3];
    h[3] = d[1] ^ d[2] ^ d[3];
    return h;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    rst       = 1'b0;
    model_cnt = 0;
  endtask

  // Shift one codeword in, LSB first; the decoder sits in RECV throughout.
  task automatic applyStimulus(input logic [6:0] code);
    for (int i = 0; i < 7; i++) begin
      in_bit   = code[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({name, " latency"}, waited, 1);
  endtask

  task automatic checkFrame(input string name, input vec_t v);
    checkOutput({name, " out_valid"}, out_valid, 1'b1);
    checkOutput({name, " in_ready"}, in_ready, 1'b0);
    checkOutput({name, " data"}, out_data, v.exp_data);
    checkOutput({name, " corrected"}, corrected, v.exp_corr);
    checkOutput({name, " err_pos"}, err_pos, v.exp_pos);
    checkOutput({name, " range_err"}, range_err, v.exp_range);
    checkOutput({name, " corr_count"}, corr_count, model_cnt);
  endtask

  task automatic releaseFrame(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({name, " out_valid cleared"}, out_valid, 1'b0);
    checkOutput({name, " in_ready back"}, in_ready, 1'b1);
  endtask

  task automatic runFrame(input string name, input vec_t v);
    applyStimulus(v.code);
    if (v.exp_corr && model_cnt < 255) model_cnt++;
    waitValid(name);
    checkFrame(name, v);
    releaseFrame(name);
  endtask

  initial begin
    vec_t v;
    vec_t v2;
    checks   = 0;
    failures = 0;

    vecs.push_back('{7'b0101101, 4'd5,  1'b0, 3'd0, 1'b0});
    vecs.push_back('{7'b0111101, 4'd5,  1'b1, 3'd5, 1'b0});
    vecs.push_back('{7'b1100001, 4'd12, 1'b0, 3'd0, 1'b1});
    vecs.push_back('{7'b0000000, 4'd0,  1'b0, 3'd0, 1'b0});
    vecs.push_back('{7'b1111111, 4'd15, 1'b0, 3'd0, 1'b1});
    vecs.push_back('{7'b1100000, 4'd12, 1'b1, 3'd1, 1'b1});
    for (int d = 0; d < 16; d++) begin
      vecs.push_back('{encode(4'(d)), 4'(d), 1'b0, 3'd0, (d > 9)});
    end
    for (int d = 0; d < 10; d++) begin
      for (int p = 0; p < 7; p++) begin
        vecs.push_back('{encode(4'(d)) ^ (7'd1 << p), 4'(d), 1'b1, 3'(p + 1), 1'b0});
      end
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    doReset();
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset out_data", out_data, 4'd0);
    checkOutput("reset err_pos", err_pos, 3'd0);
    checkOutput("reset corr_count", corr_count, 8'd0);

    $display("[TB] table: %0d frames", vecs.size());
    foreach (vecs[i]) begin
      runFrame($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: output must hold and no serial bit may be swallowed.
    v = '{7'b0101101, 4'd5, 1'b0, 3'd0, 1'b0};
    applyStimulus(v.code);
    waitValid("bp");
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkFrame($sformatf("bp hold%0d", c), v);
    end
    in_valid = 1'b0;
    releaseFrame("bp");
    v2 = '{encode(4'd9) ^ 7'b0000001, 4'd9, 1'b1, 3'd1, 1'b0};
    runFrame("bp next", v2);

    // Reset mid-frame discards the partial codeword.
    for (int i = 0; i < 3; i++) begin
      in_bit   = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    doReset();
    checkOutput("midreset corr_count", corr_count, 8'd0);
    runFrame("after midreset", v);

    // Reset while holding a frame in OUT.
    applyStimulus(7'b1100001);
    waitValid("outreset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 0;
    checkOutput("outreset out_valid", out_valid, 1'b0);
    checkOutput("outreset out_data", out_data, 4'd0);
    checkOutput("outreset range_err", range_err, 1'b0);
    checkOutput("outreset in_ready", in_ready, 1'b1);

    // Two-bit counter must saturate at 3.
    doReset();
    for (int k = 1; k <= 5; k++) begin
      v2 = '{encode(4'd3) ^ 7'b0000100, 4'd3, 1'b1, 3'd3, 1'b0};
      applyStimulus(v2.code);
      model_cnt++;
      waitValid($sformatf("sat%0d", k));
      checkFrame($sformatf("sat%0d", k), v2);
      checkOutput($sformatf("sat%0d count", k), sat_corr_count, (k > 3) ? 3 : k);
      checkOutput($sformatf("sat%0d data", k), sat_out_data, 4'd3);
      releaseFrame($sformatf("sat%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
